// File: rtl/seq_divider.sv
// Multi-cycle restoring divider, BITS_PER_CYCLE quotient bits per clock.
// Define DIV_SIGNED_EN to add the signed_mode port (two's complement divide).
module seq_divider #(
    parameter int N              = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
`ifdef DIV_SIGNED_EN
    input  logic         signed_mode,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int ITERS = N / BITS_PER_CYCLE;
    localparam int CW    = $clog2(ITERS + 1);

    generate
        if ((N < 2) || (BITS_PER_CYCLE < 1) ||
            (N % BITS_PER_CYCLE != 0)) begin : g_bad_cfg
            $error("seq_divider: BITS_PER_CYCLE must divide N");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_n;

    logic [CW-1:0] cnt;
    logic [N:0]    rem;
    logic [N-1:0]  qsh;
    logic [N-1:0]  dvsr;

    logic          accept;
    logic          zero_div;
    logic          last;
    logic [N-1:0]  a_mag;
    logic [N-1:0]  b_mag;
    logic [N:0]    rem_n;
    logic [N-1:0]  qsh_n;
    logic [N+1:0]  trial;
    logic [N-1:0]  q_fin;
    logic [N-1:0]  r_fin;

`ifdef DIV_SIGNED_EN
    logic          neg_q;
    logic          neg_r;
    logic          neg_q_in;
    logic          neg_r_in;
    logic          neg_d_in;

    assign neg_r_in = signed_mode & dividend[N-1];
    assign neg_d_in = signed_mode & divisor[N-1];
    assign neg_q_in = neg_r_in ^ neg_d_in;
    assign a_mag    = neg_r_in ? -dividend : dividend;
    assign b_mag    = neg_d_in ? -divisor : divisor;
    assign q_fin    = neg_q ? -qsh_n : qsh_n;
    assign r_fin    = neg_r ? -rem_n[N-1:0] : rem_n[N-1:0];
`else
    assign a_mag    = dividend;
    assign b_mag    = divisor;
    assign q_fin    = qsh_n;
    assign r_fin    = rem_n[N-1:0];
`endif

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign zero_div  = (divisor == '0);
    assign last      = (cnt == CW'(1));

    // qsh holds unconsumed dividend bits at the top, quotient bits enter at the bottom
    always_comb begin
        rem_n = rem;
        qsh_n = qsh;
        trial = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            rem_n = {rem_n[N-1:0], qsh_n[N-1]};
            qsh_n = {qsh_n[N-2:0], 1'b0};
            trial = {1'b0, rem_n} - {2'b00, dvsr};
            if (!trial[N+1]) begin
                rem_n    = trial[N:0];
                qsh_n[0] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_n = zero_div ? DONE : CALC;
                end
            end
            CALC: begin
                if (last) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            rem         <= '0;
            qsh         <= '0;
            dvsr        <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            unique case (1'b1)
                accept: begin
                    cnt         <= CW'(ITERS);
                    rem         <= '0;
                    qsh         <= a_mag;
                    dvsr        <= b_mag;
                    div_by_zero <= zero_div;
`ifdef DIV_SIGNED_EN
                    neg_q       <= neg_q_in;
                    neg_r       <= neg_r_in;
`endif
                    if (zero_div) begin
                        quotient  <= '1;
                        remainder <= dividend;
                    end
                end
                (state == CALC): begin
                    cnt <= cnt - CW'(1);
                    rem <= rem_n;
                    qsh <= qsh_n;
                    if (last) begin
                        quotient  <= q_fin;
                        remainder <= r_fin;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle, parametrised restoring integer divider with a valid/ready handshake on input and output.
- Successor to the team's combinational N-iteration divider. It trades latency for area by doing BITS_PER_CYCLE restoring steps per clock.
- Adds divide-by-zero detection, output back-pressure and, optionally, signed division.
- Used by the datapath wherever a quotient/remainder is needed without a full-width combinational array.

Parameters:
- N, 32, operand / quotient / remainder width in bits (>=2).
- BITS_PER_CYCLE, 1, restoring iterations per clock. Must divide N exactly; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  operands present
- in_ready  output  1  divider can accept operands
- dividend  input  N  dividend
- divisor  input  N  divisor
- out_valid  output  1  result present
- out_ready  input  1  consumer accepts result
- quotient  output  N  quotient
- remainder  output  N  remainder
- div_by_zero  output  1  result came from a zero divisor; qualified by out_valid

Behaviour:
- States: IDLE, CALC, DONE. Reset forces IDLE from any state, including mid-CALC; the in-flight operation is discarded with no output.
- Reset values: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
- in_ready=1 only in IDLE. out_valid=1 only in DONE.
- Accept: an edge with in_valid & in_ready.
  - Operands are registered. Iteration counter is loaded with N/BITS_PER_CYCLE.
  - divisor==0: go directly to DONE. quotient=all ones, remainder=dividend, div_by_zero=1. out_valid rises 1 cycle after accept.
  - Otherwise: go to CALC.
- CALC, each edge performs BITS_PER_CYCLE restoring steps, MSB of dividend first:
  - rem = {rem[N-1:0], next dividend bit};
  - trial = rem - divisor, using an N+1-bit remainder register;
  - if trial is non-negative: rem = trial, quotient bit = 1; else keep rem, quotient bit = 0.
- The counter decrements each CALC edge. The edge where it reaches 0 moves to DONE.
- out_valid rises exactly N/BITS_PER_CYCLE cycles after the accept edge. Examples: 32 cycles for N=32, K=1; 8 cycles for K=4.
- DONE: quotient, remainder and div_by_zero are held stable while out_valid=1 && out_ready=0.
- On an edge with out_valid & out_ready: return to IDLE. in_ready=1 the next cycle; no same-cycle re-accept.
- in_valid seen in CALC or DONE is ignored; the operands are not captured.
- Operands are sampled only at accept. Changes to dividend/divisor afterwards do not affect the result.
- Unsigned results satisfy dividend == quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.

Optional Feature:
- Macro: DIV_SIGNED_EN.
- Defined:
  - Adds input port signed_mode (1 bit), sampled at accept.
  - signed_mode=1: operands are two's complement. The core divides magnitudes, and the sign is applied on the final CALC edge, so latency is unchanged.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - Overflow case -2^(N-1) / -1: quotient=-2^(N-1), remainder=0, div_by_zero=0.
  - Divide by zero in signed mode: quotient = -1 (all ones), remainder = dividend.
  - signed_mode=0 behaves exactly as the unsigned block.
- Undefined: the signed_mode port is absent and the divider is unsigned-only.

Test Plan:
- N=32, K=1. Accept 14/3 with out_ready=1 → out_valid exactly 32 cycles after accept; quotient=4, remainder=2, div_by_zero=0; in_ready=1 the cycle after handshake.
- N=32, K=4. Back-to-back 5001/5 then 900/9 → 1000 r1, then 100 r0; each result 8 cycles after its accept; in_ready low throughout CALC/DONE.
- Divide by zero. Accept 900/0 → out_valid 1 cycle later; quotient=32'hFFFF_FFFF, remainder=900, div_by_zero=1.
- Back-pressure. 333/1 with out_ready=0 for 10 cycles after out_valid → quotient=333, remainder=0 held stable and in_ready=0 throughout; handshake on the edge out_ready rises.
- Reset mid-operation. Assert reset 5 cycles into CALC of 14/3 → next cycle in_ready=1, out_valid=0; a following 7/7 completes to 1 r0.
- DIV_SIGNED_EN, signed_mode=1:
  - -7/2 → -3 r-1;
  - 7/-2 → -3 r1;
  - 32'h8000_0000 / -1 → quotient=32'h8000_0000, remainder=0.
